// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the program-counter fetch controller.
package pc_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_e;

    localparam int unsigned PC_WIDTH = 32;
    localparam logic [PC_WIDTH-1:0] PC_INC = 32'd4;

endpackage

// File: rtl/pc_next_adder.sv
// Next-PC adder: sequential pc+4 or taken-branch pc+imm_ext, wrapping modulo 2^32.
module pc_next_adder
    import pc_fetch_ctrl_pkg::*;
(
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [PC_WIDTH-1:0] imm_ext,
    input  logic                pc_src,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic [PC_WIDTH-1:0] next_pc
);

    assign pc_plus4 = pc + PC_INC;
    assign next_pc  = pc_src ? (pc + imm_ext) : pc_plus4;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch controller: owns the PC register, the IDLE/FETCH/HALT sequencer and the
// sticky misalign trap; a misaligned branch target freezes the PC and halts fetch.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_src,
    input  logic [31:0] imm_ext,
    input  logic        stall,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        misalign
);

    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("RESET_PC must be word aligned");
    end

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                instr_valid_q, instr_valid_d;
    logic                misalign_q, misalign_d;
    logic [PC_WIDTH-1:0] next_pc;

    pc_next_adder u_pc_next_adder (
        .pc       (pc_q),
        .imm_ext  (imm_ext),
        .pc_src   (pc_src),
        .pc_plus4 (pc_plus4),
        .next_pc  (next_pc)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_valid_d = 1'b0;
        misalign_d    = misalign_q;
        imem_req      = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = !stall;
                // stall overrides a concurrent ready strobe
                if (!stall && imem_ready) begin
                    instr_valid_d = 1'b1;
                    if (next_pc[1:0] != 2'b00) begin
                        state_d    = HALT;
                        misalign_d = 1'b1;
                    end else begin
                        pc_d = next_pc;
                    end
                end
            end
            HALT: begin
                misalign_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_valid_q <= instr_valid_d;
            misalign_q    <= misalign_d;
        end
    end

    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign instr_valid = instr_valid_q;
    assign misalign    = misalign_q;

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-004 pc_src  input  1  SHALL be the branch-taken select (Branch AND Zero) from the branch AND stage.
REQ-005 imm_ext  input  32  SHALL be the sign-extended branch offset in bytes.
REQ-006 stall  input  1  SHALL be the hold-fetch request from downstream.
REQ-007 imem_ready  input  1  SHALL be the instruction-memory acceptance/data-valid strobe.
REQ-008 imem_req  output  1  SHALL be the fetch request to instruction memory.
REQ-009 imem_addr  output  32  SHALL be the fetch address, always equal to pc.
REQ-010 pc  output  32  SHALL be the current program counter.
REQ-011 pc_plus4  output  32  SHALL be pc + 4, combinational.
REQ-012 instr_valid  output  1  SHALL pulse high for one cycle per completed fetch.
REQ-013 misalign  output  1  SHALL flag a misaligned next-PC trap (sticky).

Function
REQ-014 The FSM SHALL have three states: IDLE, FETCH, HALT.
REQ-015 IDLE SHALL last exactly one cycle after reset release, with imem_req=0, then go to FETCH.
REQ-016 In FETCH, imem_req SHALL equal !stall.
REQ-017 A fetch SHALL complete in a cycle where state==FETCH, stall==0 and imem_ready==1; completion at the next edge gives instr_valid=1 for that one cycle.
REQ-018 At a completing edge, next_pc SHALL be pc + imm_ext when pc_src==1, else pc + 4, with pc_src and imm_ext sampled in the completing cycle.
REQ-019 All PC arithmetic SHALL be 32-bit modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000), with no overflow flag.
REQ-020 If next_pc[1:0] != 2'b00 at a completing edge, pc SHALL hold, state SHALL go to HALT, misalign SHALL go to 1, and instr_valid SHALL still pulse.
REQ-021 In FETCH with imem_ready==0 or stall==1, pc SHALL hold and instr_valid SHALL be 0.
REQ-022 stall and imem_ready high together SHALL count as no completion (stall wins).
REQ-023 pc_src asserted in a non-completing cycle SHALL be ignored.
REQ-024 Back-to-back fetches SHALL sustain one instruction per cycle while imem_ready stays high and stall stays low.
REQ-025 HALT SHALL be left only by reset; in HALT imem_req=0, instr_valid=0, misalign=1, pc held.

Reset
REQ-026 With rst_n==0 at a rising edge, the block SHALL set pc=RESET_PC, state=IDLE, instr_valid=0, misalign=0 and imem_req=0, overriding any in-flight fetch.
REQ-027 A reset during FETCH with imem_ready high SHALL discard that fetch (no instr_valid pulse).
REQ-028 RESET_PC with bits [1:0] != 0 SHALL be a parameter error, checked at elaboration.

Structure
REQ-029 The shared package SHALL hold the FSM state typedef (IDLE/FETCH/HALT), the PC_WIDTH=32 constant and the PC_INC=4 constant.
REQ-030 The block SHALL contain one sub-module, pc_next_adder: a combinational adder that selects pc+4 or pc+imm_ext on pc_src.
REQ-031 The PC register, FSM and misalign flag SHALL stay in pc_fetch_ctrl.

Verification
REQ-032 Reset then run: RESET_PC=0, imem_ready=1, pc_src=0 for 4 cycles -> after IDLE, pc steps 0,4,8,C; instr_valid high each cycle.
REQ-033 Branch: pc=32'h10, pc_src=1, imm_ext=32'hFFFF_FFF8 in the completing cycle -> pc=32'h08 at the next edge.
REQ-034 Stall/ready mix: pc=32'h20; cycle1 stall=1, ready=1; cycle2 stall=0, ready=0; cycle3 stall=0, ready=1 -> pc holds 32'h20 through cycle2, becomes 32'h24 after cycle3, single instr_valid pulse.
REQ-035 Misalign: pc=32'h40, pc_src=1, imm_ext=32'h6 -> misalign=1, state HALT, pc stays 32'h40, imem_req=0 until rst_n low.
REQ-036 Wrap-around: pc=32'hFFFF_FFFC, pc_src=0, ready=1 -> pc=32'h0000_0000.
REQ-037 Mid-fetch reset: in FETCH with ready=1, rst_n=0 for one edge -> no instr_valid pulse, pc=RESET_PC, state IDLE.
